// File: rtl/register_option_spi.sv
// Sensor register programmer: SPI mode-0 master that writes, reads back and verifies a fixed table after reset.
// Each frame takes 26 bits of 25 clocks; there is no host-side handshake, and the sequence runs once per reset.
module register_option_spi #(
    parameter int BIT_CYCLES     = 25,
    parameter int SCK_LOW_CYCLES = 12,
    parameter int POWERUP_CYCLES = 100,
    parameter int GAP_CYCLES     = 50,
    parameter int NUM_REGS       = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic sys_clk_50M,
    input  logic sys_reset_n,
    input  logic data_miso_in,
    output logic ss_n,
    output logic data_mosi_out,
    output logic sck,
    output logic spi_in_flag
);

    localparam int FRAME_BITS = 26;
    localparam int RD_FIRST   = 10;
    localparam int CLK_W      = $clog2(BIT_CYCLES);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int PWR_W      = $clog2(POWERUP_CYCLES);
    localparam int GAP_W      = $clog2(GAP_CYCLES);
    localparam int IDX_W      = $clog2(NUM_REGS + 1);
    localparam int RETRY_W    = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        WAIT_PWR,
        LOAD,
        WR_FRAME,
        GAP,
        RD_FRAME,
        CHECK,
        DONE
    } state_t;

    state_t state, state_nxt;
    state_t after_gap, after_gap_nxt;

    logic [PWR_W-1:0]      pwr_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [CLK_W-1:0]      clk_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [RETRY_W-1:0]    retry, retry_nxt;
    logic [FRAME_BITS-1:0] shift;
    logic [15:0]           rd_data;
    logic [8:0]            entry_addr;
    logic [15:0]           entry_data;

    logic in_frame, in_frame_nxt, bit_end, frame_end, sample_miso;

    always_comb begin
        entry_addr = 9'h000;
        entry_data = 16'h0000;
        case (idx)
            IDX_W'(0): begin entry_addr = 9'h008; entry_data = 16'h0000; end
            IDX_W'(1): begin entry_addr = 9'h010; entry_data = 16'h0003; end
            IDX_W'(2): begin entry_addr = 9'h020; entry_data = 16'h8421; end
            IDX_W'(3): begin entry_addr = 9'h0C0; entry_data = 16'h0001; end
            default:   begin entry_addr = 9'h000; entry_data = 16'h0000; end
        endcase
    end

    assign in_frame     = (state == WR_FRAME) || (state == RD_FRAME);
    assign in_frame_nxt = (state_nxt == WR_FRAME) || (state_nxt == RD_FRAME);
    assign bit_end      = clk_cnt == CLK_W'(BIT_CYCLES - 1);
    assign frame_end    = bit_end && (bit_idx == BIT_W'(FRAME_BITS - 1));
    // MISO is captured on the edge that raises sck.
    assign sample_miso  = (state == RD_FRAME) && (bit_idx >= BIT_W'(RD_FIRST)) &&
                          (clk_cnt == CLK_W'(SCK_LOW_CYCLES - 1));

    always_comb begin
        state_nxt     = state;
        after_gap_nxt = after_gap;
        idx_nxt       = idx;
        retry_nxt     = retry;
        case (state)
            WAIT_PWR: if (pwr_cnt == PWR_W'(POWERUP_CYCLES - 2)) state_nxt = LOAD;
            LOAD: begin
                retry_nxt = '0;
                state_nxt = WR_FRAME;
            end
            WR_FRAME: if (frame_end) begin
                state_nxt     = GAP;
                after_gap_nxt = RD_FRAME;
            end
            RD_FRAME: if (frame_end) state_nxt = CHECK;
            CHECK: begin
                state_nxt = GAP;
                if (rd_data == entry_data || retry == RETRY_W'(MAX_RETRY)) begin
                    idx_nxt       = idx + IDX_W'(1);
                    after_gap_nxt = (idx + IDX_W'(1) == IDX_W'(NUM_REGS)) ? DONE : LOAD;
                end else begin
                    retry_nxt     = retry + RETRY_W'(1);
                    after_gap_nxt = WR_FRAME;
                end
            end
            GAP: if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = after_gap;
            DONE: state_nxt = DONE;
            default: state_nxt = WAIT_PWR;
        endcase
    end

    always_ff @(posedge sys_clk_50M) begin
        if (!sys_reset_n) begin
            state     <= WAIT_PWR;
            after_gap <= LOAD;
            idx       <= '0;
            retry     <= '0;
        end else begin
            state     <= state_nxt;
            after_gap <= after_gap_nxt;
            idx       <= idx_nxt;
            retry     <= retry_nxt;
        end
    end

    always_ff @(posedge sys_clk_50M) begin
        if (!sys_reset_n) begin
            pwr_cnt <= '0;
            gap_cnt <= '0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rd_data <= '0;
        end else begin
            if (state == WAIT_PWR) pwr_cnt <= pwr_cnt + PWR_W'(1);

            if (state == GAP && state_nxt == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else gap_cnt <= '0;

            if (in_frame) begin
                if (bit_end) begin
                    clk_cnt <= '0;
                    bit_idx <= frame_end ? '0 : bit_idx + BIT_W'(1);
                    shift   <= {shift[FRAME_BITS-2:0], 1'b0};
                end else begin
                    clk_cnt <= clk_cnt + CLK_W'(1);
                end
            end else begin
                clk_cnt <= '0;
                bit_idx <= '0;
                // Read frames carry only address and rw; the data slots stay low.
                if (in_frame_nxt)
                    shift <= (state_nxt == WR_FRAME) ? {entry_addr, 1'b1, entry_data}
                                                     : {entry_addr, 1'b0, 16'h0000};
            end

            if (sample_miso) rd_data <= {rd_data[14:0], data_miso_in};
        end
    end

    assign ss_n          = !in_frame;
    assign sck           = in_frame && (clk_cnt >= CLK_W'(SCK_LOW_CYCLES));
    assign data_mosi_out = in_frame && shift[FRAME_BITS-1];
    assign spi_in_flag   = (state == RD_FRAME) && (bit_idx >= BIT_W'(RD_FIRST));

endmodule

// File: tb/tb_register_option_spi.sv
// Bench for register_option_spi: a frame-level model of the write/verify sequence checked every clock.
module tb_register_option_spi;

    logic clk = 1'b0;
    logic rst_n, miso;
    logic ss_n, mosi, sck, flag;

    always #10 clk = ~clk;

    register_option_spi dut (
        .sys_clk_50M  (clk),
        .sys_reset_n  (rst_n),
        .data_miso_in (miso),
        .ss_n         (ss_n),
        .data_mosi_out(mosi),
        .sck          (sck),
        .spi_in_flag  (flag)
    );

    logic [8:0]  t_addr [4] = '{9'h008, 9'h010, 9'h020, 9'h0C0};
    logic [15:0] t_data [4] = '{16'h0000, 16'h0003, 16'h8421, 16'h0001};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model and monitor state
    int          mode = 0;
    logic        rst_q = 1'b0;
    int          since_rst, t, frames, first_fall, gap_len;
    bit          in_frame, cur_read, expect_read, m_done;
    int          m_idx, m_retry;
    logic [25:0] cur_word, cap_word, first_word;
    logic [15:0] drive_val;
    int          rise_t, flag_cnt, meas_rise, meas_len;

    always @(posedge clk) rst_q = rst_n;

    task automatic model_advance();
        if (!cur_read) begin
            expect_read = 1'b1;
        end else begin
            expect_read = 1'b0;
            if (drive_val == t_data[m_idx] || m_retry == 3) begin
                m_idx++;
                m_retry = 0;
                if (m_idx == 4) m_done = 1'b1;
            end else begin
                m_retry++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_q) begin
            check("reset_ss_n", ss_n, 1);
            check("reset_sck", sck, 0);
            check("reset_mosi", mosi, 0);
            check("reset_flag", flag, 0);
            since_rst = 0; in_frame = 0; frames = 0; first_fall = -1; gap_len = 0;
            m_idx = 0; m_retry = 0; m_done = 0; expect_read = 0;
            miso = 1'b0;
        end else begin
            since_rst++;
            if (in_frame && ss_n === 1'b1) begin
                check("frame_len", t, 650);
                if (cur_read && frames == 2) begin
                    meas_rise = rise_t;
                    meas_len  = flag_cnt;
                end
                if (frames == 1) first_word = cap_word;
                model_advance();
                in_frame = 0;
                gap_len  = 0;
                miso     = 1'b0;
            end else if (!in_frame && ss_n === 1'b0) begin
                if (first_fall < 0) begin
                    first_fall = since_rst;
                    check("powerup_delay", since_rst, 100);
                end else begin
                    check("gap_min", gap_len >= 50, 1);
                end
                check("frame_after_done", m_done, 0);
                in_frame = 1; t = 0; cap_word = '0; rise_t = -1; flag_cnt = 0;
                cur_read = expect_read;
                frames++;
                if (m_idx < 4) begin
                    cur_word = cur_read ? {t_addr[m_idx], 1'b0, 16'h0000}
                                        : {t_addr[m_idx], 1'b1, t_data[m_idx]};
                    case (mode)
                        0:       drive_val = 16'h8421;
                        1:       drive_val = t_data[m_idx];
                        default: drive_val = ($urandom_range(0, 1) == 1) ? t_data[m_idx]
                                                                         : 16'($urandom);
                    endcase
                end
            end

            if (in_frame) begin
                if (t < 650) begin
                    check("sck", sck, ((t % 25) >= 12) ? 1 : 0);
                    check("mosi", mosi, cur_word[25 - t / 25]);
                    check("flag", flag, (cur_read && t >= 250) ? 1 : 0);
                end else if (t == 650) begin
                    check("frame_overrun", t, 649);
                end
                if (flag === 1'b1) begin
                    if (rise_t < 0) rise_t = t;
                    flag_cnt++;
                end
                if ((t % 25) == 12) cap_word = {cap_word[24:0], mosi};
                if (cur_read && t >= 250 && t < 650 && ((t - 250) % 25) == 0)
                    miso = drive_val[15 - (t - 250) / 25];
                t++;
            end else begin
                check("idle_sck", sck, 0);
                check("idle_mosi", mosi, 0);
                check("idle_flag", flag, 0);
                gap_len++;
            end
        end
    end

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (m_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(name, 0, 1);
        repeat (300) @(negedge clk);
    endtask

    task automatic do_reset(input int clocks);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (clocks) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0;
        miso  = 1'b0;
        meas_rise = -1;
        meas_len  = -1;

        // Readback always 8421: only entry 2 verifies, the others exhaust their retries.
        mode = 0;
        do_reset(3);
        wait_done("timeout_mismatch");
        check("mismatch_frames", frames, 26);
        check("frame0_word", first_word, 32'h0110000);
        check("flag_rise_t", meas_rise, 250);
        check("flag_len", meas_len, 400);

        // Echoing readback: one write/read pair per entry.
        mode = 1;
        do_reset(1);
        wait_done("timeout_match");
        check("match_frames", frames, 8);
        check("match_frame0_word", first_word, 32'h0110000);

        // Random readback, with a reset landing in bit 15 of a read frame.
        mode = 2;
        do_reset(1);
        hit = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (in_frame && cur_read && t == 380) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_read_bit15", hit, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ss_n", ss_n, 1);
        check("midreset_sck", sck, 0);
        check("midreset_flag", flag, 0);
        rst_n = 1'b1;
        wait_done("timeout_random");
        check("random_restart_delay", first_fall, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
